// File: rtl/inst_fetch_stage.sv
// inst_fetch_stage
//   IF stage plus IF/ID pipeline register of a 5-stage MIPS pipeline.
//   Holds the fetch PC and fetches from a variable-latency instruction memory
//   using a req/ready handshake. A returned word is parked in a one-entry
//   buffer when the pipeline cannot take it. The next PC is computed from the
//   redirect request of the instruction currently in ID, so the word being
//   fetched in the same cycle is that instruction's delay slot.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   if_en, if_rst        IF stage enable / IF stage reset (PC, fetch state)
//   id_en, id_rst        IF/ID register enable / flush
//   pc_src               next-PC select for the instruction in ID
//   rs_rt_equal          rs==rt for the instruction in ID (branch condition)
//   rs_data_id           forwarded rs value in ID (JR target)
//   imem_req, imem_addr  fetch request and address (address = pc)
//   imem_ready           read data valid this cycle (ignored when imem_req=0)
//   imem_rdata           fetched word
//   inst_id, pc_id       instruction in ID and its address (NOP when invalid)
//   valid_id             inst_id is a real instruction
//   imem_stall           fetch outstanding and data not yet returned
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [2:0]  PC_NEXT  = 3'd0,
    parameter logic [2:0]  PC_JUMP  = 3'd1,
    parameter logic [2:0]  PC_JR    = 3'd2,
    parameter logic [2:0]  PC_BEQ   = 3'd3,
    parameter logic [2:0]  PC_BNE   = 3'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_en,
    input  logic        if_rst,
    input  logic        id_en,
    input  logic        id_rst,
    input  logic [2:0]  pc_src,
    input  logic        rs_rt_equal,
    input  logic [31:0] rs_data_id,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_id,
    output logic [31:0] pc_id,
    output logic        valid_id,
    output logic        imem_stall
);

    typedef enum logic [0:0] {StFetch, StBuffered} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] buf_q;
    logic [31:0] inst_id_q;
    logic [31:0] pc_id_q;
    logic        valid_id_q;

    logic        avail;
    logic        advance;
    logic        capture;
    logic [31:0] word;
    logic [31:0] next_pc;
    logic [31:0] p4;
    logic [31:0] q4;
    logic [31:0] boff;

    // Handshake and fetch FSM next state.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        avail    = 1'b0;
        word     = imem_rdata;
        unique case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                avail    = imem_ready;
            end
            StBuffered: begin
                avail = 1'b1;
                word  = buf_q;
            end
            default: ;
        endcase
        // A reset in the same cycle drops the word rather than loading it.
        advance = avail && if_en && id_en && !if_rst && !rst;
        capture = (state_q == StFetch) && imem_ready && !advance;
        if (capture) begin
            state_d = StBuffered;
        end else if ((state_q == StBuffered) && advance) begin
            state_d = StFetch;
        end
    end

    // Next PC. Redirects belong to the instruction in ID, so they only apply
    // when that instruction is valid.
    always_comb begin
        p4      = pc_q + 32'd4;
        q4      = pc_id_q + 32'd4;
        boff    = {{14{inst_id_q[15]}}, inst_id_q[15:0], 2'b00};
        next_pc = p4;
        if (valid_id_q) begin
            case (pc_src)
                PC_NEXT: next_pc = p4;
                PC_JUMP: next_pc = {q4[31:28], inst_id_q[25:0], 2'b00};
                PC_JR:   next_pc = {rs_data_id[31:2], 2'b00};
                PC_BEQ:  next_pc = rs_rt_equal ? (q4 + boff) : p4;
                PC_BNE:  next_pc = !rs_rt_equal ? (q4 + boff) : p4;
                default: next_pc = p4;
            endcase
        end
    end

    // IF stage state: PC, fetch FSM and the one-word return buffer.
    always_ff @(posedge clk) begin
        if (rst || if_rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (advance) begin
                pc_q <= next_pc;
            end
            if (capture) begin
                buf_q <= imem_rdata;
            end
        end
    end

    // IF/ID pipeline register. The flush wins over a load; pc_id is left as is
    // on a flush because it is meaningless while valid_id is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_id_q  <= 32'h0;
            pc_id_q    <= 32'h0;
            valid_id_q <= 1'b0;
        end else if (id_rst) begin
            inst_id_q  <= 32'h0;
            valid_id_q <= 1'b0;
        end else if (advance) begin
            inst_id_q  <= word;
            pc_id_q    <= pc_q;
            valid_id_q <= 1'b1;
        end
    end

    assign imem_addr  = pc_q;
    assign imem_stall = (state_q == StFetch) && !imem_ready;
    assign inst_id    = inst_id_q;
    assign pc_id      = pc_id_q;
    assign valid_id   = valid_id_q;

endmodule
